instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_pkg.sv | 31 +++
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch_icache.sv | 53 +++++
 rtl/instruction_fetch.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
// Module : instruction_fetch_pkg
// Brief  : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

  localparam int c_inst_w = 32;
  localparam int c_addr_w = 32;

  typedef logic [c_inst_w-1:0] inst_t;
  typedef logic [c_addr_w-1:0] addr_t;

  localparam logic c_valid   = 1'b1;
  localparam logic c_invalid = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DROP  = 2'd2
  } fetch_state_t;

  function automatic addr_t next_pc(input addr_t pc);
    return pc + addr_t'(4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module : instruction_fetch_if
// Brief  : Memory-controller and instruction-queue signals of the fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic  MC_req_valid;
  addr_t MC_addr;
  logic  MC_inst_valid;
  inst_t MC_inst;
  logic  IQ_full;
  logic  IQ_inst_valid;
  inst_t IQ_inst;
  addr_t IQ_pc;

  modport master (
    output MC_req_valid, MC_addr, IQ_inst_valid, IQ_inst, IQ_pc,
    input  MC_inst_valid, MC_inst, IQ_full
  );

  modport slave (
    input  MC_req_valid, MC_addr, IQ_inst_valid, IQ_inst, IQ_pc,
    output MC_inst_valid, MC_inst, IQ_full
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_icache.sv
// ============================================================================
// Module : icache_dm
// Brief  : Direct-mapped one-word-line instruction cache, async read, sync write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_dm
  import instruction_fetch_pkg::*;
#(
  parameter int INDEX_W = 8
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic [INDEX_W-1:0]           i_rd_index,
  input  wire logic [c_addr_w-INDEX_W-3:0]  i_rd_tag,
  output logic                              o_rd_hit,
  output inst_t                             o_rd_data,
  input  wire logic                         i_wr_en,
  input  wire logic [INDEX_W-1:0]           i_wr_index,
  input  wire logic [c_addr_w-INDEX_W-3:0]  i_wr_tag,
  input  wire inst_t                        i_wr_data
);

  localparam int c_lines = 1 << INDEX_W;
  localparam int c_tag_w = c_addr_w - INDEX_W - 2;

  logic [c_lines-1:0] r_valid;
  logic [c_tag_w-1:0] r_tag  [c_lines];
  inst_t              r_data [c_lines];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= c_valid;
    end
  end

  // Tag/data need no reset: a line is only trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_hit  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_index];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module : instruction_fetch
// Brief  : PC, I-cache lookup, miss fetch via memory controller, IQ push.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          ICACHE_INDEX_W = 8,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          rdy,
  input  wire logic          clear,
  input  wire logic [31:0]   clear_pc,
  instruction_fetch_if.master bus
);

  localparam int c_tag_w = c_addr_w - ICACHE_INDEX_W - 2;

  fetch_state_t r_state, w_state_n;
  addr_t        r_pc, w_pc_n;
  logic         r_mc_req_valid, w_mc_req_valid_n;
  addr_t        r_mc_addr, w_mc_addr_n;
  logic         r_iq_valid, w_iq_valid_n;
  inst_t        r_iq_inst, w_iq_inst_n;
  addr_t        r_iq_pc, w_iq_pc_n;

  logic         w_hit;
  inst_t        w_hit_data;
  logic         w_fill;

  icache_dm #(
    .INDEX_W (ICACHE_INDEX_W)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (r_pc[ICACHE_INDEX_W+1:2]),
    .i_rd_tag   (r_pc[31:ICACHE_INDEX_W+2]),
    .o_rd_hit   (w_hit),
    .o_rd_data  (w_hit_data),
    .i_wr_en    (w_fill),
    .i_wr_index (r_mc_addr[ICACHE_INDEX_W+1:2]),
    .i_wr_tag   (r_mc_addr[31:ICACHE_INDEX_W+2]),
    .i_wr_data  (bus.MC_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IF_IDLE;
      r_pc           <= RESET_PC;
      r_mc_req_valid <= 1'b0;
      r_mc_addr      <= '0;
      r_iq_valid     <= 1'b0;
      r_iq_inst      <= '0;
      r_iq_pc        <= '0;
    end else begin
      r_state        <= w_state_n;
      r_pc           <= w_pc_n;
      r_mc_req_valid <= w_mc_req_valid_n;
      r_mc_addr      <= w_mc_addr_n;
      r_iq_valid     <= w_iq_valid_n;
      r_iq_inst      <= w_iq_inst_n;
      r_iq_pc        <= w_iq_pc_n;
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_pc_n           = r_pc;
    w_mc_req_valid_n = r_mc_req_valid;
    w_mc_addr_n      = r_mc_addr;
    w_iq_valid_n     = 1'b0;
    w_iq_inst_n      = r_iq_inst;
    w_iq_pc_n        = r_iq_pc;
    w_fill           = 1'b0;

    if (!rdy) begin
      w_iq_valid_n = r_iq_valid;
    end else if (clear) begin
      w_pc_n = clear_pc;
      // An outstanding word still lands in the cache; only the push is lost.
      if (r_state != IF_IDLE) begin
        if (bus.MC_inst_valid) begin
          w_fill           = 1'b1;
          w_mc_req_valid_n = 1'b0;
          w_state_n        = IF_IDLE;
        end else begin
          w_state_n = IF_DROP;
        end
      end
    end else begin
      case (r_state)
        IF_IDLE: begin
          if (!bus.IQ_full) begin
            if (w_hit) begin
              w_iq_valid_n = 1'b1;
              w_iq_inst_n  = w_hit_data;
              w_iq_pc_n    = r_pc;
              w_pc_n       = next_pc(r_pc);
            end else begin
              w_mc_req_valid_n = 1'b1;
              w_mc_addr_n      = r_pc;
              w_state_n        = IF_FETCH;
            end
          end
        end
        IF_FETCH: begin
          if (bus.MC_inst_valid) begin
            w_fill           = 1'b1;
            w_iq_valid_n     = 1'b1;
            w_iq_inst_n      = bus.MC_inst;
            w_iq_pc_n        = r_mc_addr;
            w_pc_n           = next_pc(r_pc);
            w_mc_req_valid_n = 1'b0;
            w_state_n        = IF_IDLE;
          end
        end
        IF_DROP: begin
          if (bus.MC_inst_valid) begin
            w_fill           = 1'b1;
            w_mc_req_valid_n = 1'b0;
            w_state_n        = IF_IDLE;
          end
        end
        default: begin
          w_state_n = IF_IDLE;
        end
      endcase
    end
  end

  assign bus.MC_req_valid  = r_mc_req_valid;
  assign bus.MC_addr       = r_mc_addr;
  assign bus.IQ_inst_valid = r_iq_valid;
  assign bus.IQ_inst       = r_iq_inst;
  assign bus.IQ_pc         = r_iq_pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module : tb_instruction_fetch
// Brief  : Scoreboard bench for instruction_fetch with a scripted memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic [31:0] clear_pc;
  logic        rdy_q = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q[$];

  instruction_fetch_if bus();

  instruction_fetch #(
    .ICACHE_INDEX_W (8),
    .RESET_PC       (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .clear    (clear),
    .clear_pc (clear_pc),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) + 32'h13;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_push(input logic [31:0] pc);
    sb_q.push_back({mem_word(pc), pc});
  endtask

  task automatic redirect(input logic [31:0] pc);
    clear    = 1'b1;
    clear_pc = pc;
    tick(1);
    clear    = 1'b0;
  endtask

  // Waits for a request, checks its address, answers after lat cycles.
  task automatic mc_serve(input int lat, input logic [31:0] exp_addr, input bit do_push,
                          output int waited);
    waited = 0;
    while (!bus.MC_req_valid && waited < 20) begin
      tick(1);
      waited++;
    end
    check_val("mc_req_seen", {31'b0, bus.MC_req_valid}, 32'd1);
    check_val("mc_addr", bus.MC_addr, exp_addr);
    tick(lat - 1);
    bus.MC_inst_valid = 1'b1;
    bus.MC_inst       = mem_word(bus.MC_addr);
    if (do_push) expect_push(exp_addr);
    tick(1);
    bus.MC_inst_valid = 1'b0;
    bus.MC_inst       = '0;
  endtask

  always @(posedge clk) rdy_q <= rdy;

  // Queue-side consumer: a push counts only on edges where rdy was high.
  always @(negedge clk) begin
    if (!rst && rdy_q && bus.IQ_inst_valid) begin
      if (sb_q.size() == 0) begin
        check_val("push_while_sb_empty", {31'b0, bus.IQ_inst_valid}, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check_val("iq_pc", bus.IQ_pc, e[31:0]);
        check_val("iq_inst", bus.IQ_inst, e[63:32]);
      end
    end
  end

  initial begin
    int w;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; clear_pc = '0;
    bus.IQ_full = 1'b0; bus.MC_inst_valid = 1'b0; bus.MC_inst = '0;
    tick(3);
    rst = 1'b0;
    check_val("rst_mc_req_valid", {31'b0, bus.MC_req_valid}, 32'd0);
    check_val("rst_mc_addr", bus.MC_addr, 32'd0);
    check_val("rst_iq_valid", {31'b0, bus.IQ_inst_valid}, 32'd0);
    check_val("rst_iq_inst", bus.IQ_inst, 32'd0);
    check_val("rst_iq_pc", bus.IQ_pc, 32'd0);

    // Cold start and preload of 0..C through misses
    mc_serve(5, 32'h0, 1'b1, w);
    check_val("cold_req_delay", w, 32'd1);
    for (int i = 1; i < 4; i++) begin
      mc_serve(2, 32'(i * 4), 1'b1, w);
      check_val("next_req_delay", w, 32'd1);
    end
    bus.IQ_full = 1'b1;
    tick(2);
    check_val("park_no_req", {31'b0, bus.MC_req_valid}, 32'd0);

    // Hit streaming
    for (int i = 0; i < 4; i++) expect_push(32'(i * 4));
    bus.IQ_full = 1'b0;
    redirect(32'h0);
    for (int i = 0; i < 4; i++) begin
      check_val("stream_no_req", {31'b0, bus.MC_req_valid}, 32'd0);
      tick(1);
    end
    bus.IQ_full = 1'b1;
    tick(2);

    // Backpressure
    for (int i = 0; i < 4; i++) expect_push(32'(i * 4));
    bus.IQ_full = 1'b0;
    redirect(32'h0);
    tick(2);
    bus.IQ_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("full_no_push", {31'b0, bus.IQ_inst_valid}, 32'd0);
    end
    bus.IQ_full = 1'b0;
    tick(2);
    bus.IQ_full = 1'b1;
    tick(2);

    // Clear during FETCH
    bus.IQ_full = 1'b0;
    redirect(32'h40);
    tick(1);
    check_val("f40_req", {31'b0, bus.MC_req_valid}, 32'd1);
    check_val("f40_addr", bus.MC_addr, 32'h40);
    redirect(32'h100);
    check_val("drop_req_held", {31'b0, bus.MC_req_valid}, 32'd1);
    check_val("drop_addr_held", bus.MC_addr, 32'h40);
    tick(1);
    bus.MC_inst_valid = 1'b1;
    bus.MC_inst       = mem_word(32'h40);
    tick(1);
    bus.MC_inst_valid = 1'b0;
    bus.MC_inst       = '0;
    check_val("drop_req_done", {31'b0, bus.MC_req_valid}, 32'd0);
    mc_serve(2, 32'h100, 1'b1, w);
    check_val("after_drop_delay", w, 32'd1);
    bus.IQ_full = 1'b1;
    tick(2);
    expect_push(32'h40);
    bus.IQ_full = 1'b0;
    redirect(32'h40);
    tick(1);
    bus.IQ_full = 1'b1;
    check_val("hit40_no_req", {31'b0, bus.MC_req_valid}, 32'd0);
    tick(2);

    // Simultaneous clear and return in FETCH
    bus.IQ_full = 1'b0;
    redirect(32'h200);
    tick(1);
    check_val("f200_req", {31'b0, bus.MC_req_valid}, 32'd1);
    check_val("f200_addr", bus.MC_addr, 32'h200);
    bus.MC_inst_valid = 1'b1;
    bus.MC_inst       = mem_word(32'h200);
    redirect(32'h80);
    bus.MC_inst_valid = 1'b0;
    bus.MC_inst       = '0;
    check_val("simul_req_low", {31'b0, bus.MC_req_valid}, 32'd0);
    check_val("simul_no_push", {31'b0, bus.IQ_inst_valid}, 32'd0);
    mc_serve(2, 32'h80, 1'b1, w);
    check_val("simul_next_delay", w, 32'd1);
    bus.IQ_full = 1'b1;
    tick(2);
    expect_push(32'h200);
    bus.IQ_full = 1'b0;
    redirect(32'h200);
    tick(1);
    bus.IQ_full = 1'b1;
    check_val("hit200_no_req", {31'b0, bus.MC_req_valid}, 32'd0);
    tick(2);

    // PC wrap
    bus.IQ_full = 1'b0;
    redirect(32'hFFFF_FFFC);
    mc_serve(2, 32'hFFFF_FFFC, 1'b1, w);
    bus.IQ_full = 1'b1;
    tick(2);
    expect_push(32'hFFFF_FFFC);
    expect_push(32'h0);
    bus.IQ_full = 1'b0;
    redirect(32'hFFFF_FFFC);
    tick(2);
    bus.IQ_full = 1'b1;
    check_val("wrap_no_req", {31'b0, bus.MC_req_valid}, 32'd0);
    tick(2);

    // rdy low freezes state and outputs
    expect_push(32'h0);
    expect_push(32'h4);
    bus.IQ_full = 1'b0;
    redirect(32'h0);
    tick(1);
    rdy = 1'b0;
    tick(1);
    check_val("frozen_iq_valid", {31'b0, bus.IQ_inst_valid}, 32'd1);
    check_val("frozen_iq_pc", bus.IQ_pc, 32'h0);
    tick(1);
    rdy = 1'b1;
    tick(1);
    bus.IQ_full = 1'b1;
    check_val("resume_iq_pc", bus.IQ_pc, 32'h4);
    tick(2);

    // Reset invalidates the cache: address 0 misses again
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    bus.IQ_full = 1'b0;
    mc_serve(3, 32'h0, 1'b1, w);
    check_val("rst_inval_delay", w, 32'd1);
    bus.IQ_full = 1'b1;
    tick(3);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
